multicycle_controller: RTL
==========================

# multicycle_controller

Parametrised multi-cycle main control FSM for the RISC-V core. It replaces the single-cycle opcode decoder with a sequenced controller that shares one memory port and one ALU across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states. It waits on a memory ready handshake with a bounded timeout, supports branch and JAL, and traps on illegal opcodes. It sits between the instruction register, which supplies the opcode, and the datapath muxes and enables.

## Interface
- ALUOP_W, 2: width of alu_op (≥2); codes are zero-extended.
- TIMEOUT_CYCLES, 16: mem_ready-low cycles tolerated per memory request; 0 disables the timeout.
- ENABLE_JAL, 1: when 0, opcode 1101111 is decoded as illegal.

Ports (all outputs are combinational from state, except fault_code):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0], sampled in DECODE
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write request (valid with mem_req)
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- reg_write  out  1  register-file write
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4
- alu_op  out  ALUOP_W  0 = add, 1 = sub, 2 = funct-decoded
- result_src  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result
- instr_done  out  1  one-cycle pulse on the final state of every instruction
- fault  out  1  sticky trap indicator
- fault_code  out  2  01 = illegal opcode, 10 = bus timeout; registered
- state  out  4  current state encoding, for debug

## Operation
- States and encodings: RST=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADR=5, MEM_RD=6, MEM_WR=7, ALU_WB=8, MEM_WB=9, BRANCH=10, JAL=11, TRAP=12.
- **RST:** all outputs 0. Next state is FETCH.
- **FETCH:** mem_req=1, adr_src=0, src_a=00, src_b=10, add, result_src=10.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1, and the FSM then goes to DECODE.
  - Otherwise the FSM stays in FETCH.
- **DECODE:** src_a=01, src_b=01, add, computing the branch target into ALUOut. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → TRAP with fault_code=01
- **EXEC_R:** src_a=10, src_b=00, alu_op=2. Next state is ALU_WB.
- **EXEC_I:** src_a=10, src_b=01, alu_op=2. Next state is ALU_WB.
- **MEM_ADR:** src_a=10, src_b=01, add. Next state is MEM_RD for a load, MEM_WR for a store.
- **MEM_RD:** mem_req=1, adr_src=1. Waits for mem_ready, then goes to MEM_WB.
- **MEM_WR:** mem_req=1, mem_we=1, adr_src=1. Waits for mem_ready; that cycle asserts instr_done and goes to FETCH.
- **ALU_WB:** reg_write=1, result_src=00, instr_done=1. Next state is FETCH.
- **MEM_WB:** reg_write=1, result_src=01, instr_done=1. Next state is FETCH.
- **BRANCH:** src_a=10, src_b=00, sub, result_src=00. pc_write=zero (BEQ only), instr_done=1. Next state is FETCH.
- **JAL:** src_a=01, src_b=10, add, result_src=00, pc_write=1. Next state is ALU_WB, which writes oldPC+4.
- **TRAP:** all enables 0, mem_req=0, fault=1. Exit only via reset.
- **Timeout counter:**
  - Width is clog2(TIMEOUT_CYCLES+1).
  - Increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0.
  - Clears on mem_ready=1 or on leaving the wait state.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to TRAP with fault_code=10 and no side effects in that cycle.
- mem_ready outside the request states is ignored. opcode is don't-care outside DECODE.

## Timing
- Reset: asynchronous. state=RST, counter=0, fault_code=0, and every output reads 0 while rst_n=0 and in the first cycle after release.
- Latency with zero memory wait:
  - R, I, store, JAL: 4 cycles
  - load: 5 cycles
  - branch: 3 cycles
  - Each mem_ready-low cycle adds one cycle.
- mem_req, mem_we and adr_src remain stable from request start until the mem_ready cycle.
- mem_ready arriving in the same cycle the counter reaches TIMEOUT_CYCLES: ready wins and there is no trap.
- Reset during a wait: the request drops asynchronously, and the next fetch restarts via RST.

## Test plan
- **Reset:** rst_n low mid-MEM_RD → state=0, all outputs 0 immediately; after release, FETCH on the second cycle.
- **Zero-wait sequence:** opcodes 0110011, 0000011, 0100011, 1100011 with zero=1, mem_ready=1 → instr_done spacing 4, 5, 4, 3 cycles; the branch asserts pc_write in BRANCH.
- **Waited load:** mem_ready low 3 cycles in MEM_RD → 8-cycle load, mem_req/adr_src stable throughout, reg_write only in MEM_WB.
- **Illegal opcode:** opcode 0001111 → TRAP, fault=1, fault_code=01, no further mem_req; with ENABLE_JAL=0, 1101111 gives the same result.
- **Timeout:** TIMEOUT_CYCLES=4, mem_ready never high in FETCH → TRAP after 4 wait cycles, fault_code=10. Ready on the 4th cycle → no trap.
- **JAL:** opcode 1101111 → pc_write in JAL, reg_write with result_src=00 in ALU_WB, 4 cycles total.

Source files
------------

// File: rtl/multicycle_controller.sv
// ============================================================================
//  Module      : multicycle_controller
//  Description : Multi-cycle main control FSM for the RISC-V core. It sequences
//                one shared memory port and one ALU through fetch, decode,
//                execute, memory and writeback. It also traps on illegal
//                opcodes and on memory timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
    parameter int ALUOP_W        = 2,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ENABLE_JAL     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         result_src,
    output logic               instr_done,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [3:0]         state
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_cnt_w'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    localparam logic [ALUOP_W-1:0] c_alu_add   = '0;
    localparam logic [ALUOP_W-1:0] c_alu_sub   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] c_alu_funct = ALUOP_W'(2);

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    localparam logic [1:0] c_fc_illegal = 2'b01;
    localparam logic [1:0] c_fc_timeout = 2'b10;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_EXEC_I  = 4'd4,
        S_MEM_ADR = 4'd5,
        S_MEM_RD  = 4'd6,
        S_MEM_WR  = 4'd7,
        S_ALU_WB  = 4'd8,
        S_MEM_WB  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JAL     = 4'd11,
        S_TRAP    = 4'd12
    } state_e;

    state_e             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [1:0]         fault_code_q, fault_code_d;
    logic               is_store_q, is_store_d;

    logic w_wait;
    logic w_timeout;

    assign w_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // The trap fires on the cycle the stall count would reach the limit; a ready in that cycle wins.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_wait && !mem_ready && (cnt_q == c_cnt_last);

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        fault_code_d = fault_code_q;
        is_store_d   = is_store_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = c_alu_add;
        result_src   = 2'b00;
        instr_done   = 1'b0;
        fault        = 1'b0;

        if ((TIMEOUT_CYCLES != 0) && w_wait && !mem_ready && !w_timeout) begin
            cnt_d = cnt_q + c_cnt_w'(1);
        end

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (w_timeout) begin
                    state_d      = S_TRAP;
                    fault_code_d = c_fc_timeout;
                end
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                is_store_d = (opcode == c_op_store);
                case (opcode)
                    c_op_r:                 state_d = S_EXEC_R;
                    c_op_i:                 state_d = S_EXEC_I;
                    c_op_load, c_op_store:  state_d = S_MEM_ADR;
                    c_op_branch:            state_d = S_BRANCH;
                    c_op_jal: begin
                        if (ENABLE_JAL != 0) begin
                            state_d = S_JAL;
                        end else begin
                            state_d      = S_TRAP;
                            fault_code_d = c_fc_illegal;
                        end
                    end
                    default: begin
                        state_d      = S_TRAP;
                        fault_code_d = c_fc_illegal;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = c_alu_funct;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = c_alu_funct;
                state_d   = S_ALU_WB;
            end
            S_MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = is_store_q ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (w_timeout) begin
                    state_d      = S_TRAP;
                    fault_code_d = c_fc_timeout;
                end
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (w_timeout) begin
                    state_d      = S_TRAP;
                    fault_code_d = c_fc_timeout;
                end
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                result_src = 2'b00;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op     = c_alu_sub;
                result_src = 2'b00;
                pc_write   = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b00;
                pc_write   = 1'b1;
                state_d    = S_ALU_WB;
            end
            S_TRAP: begin
                fault   = 1'b1;
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RST;
            cnt_q        <= '0;
            fault_code_q <= 2'b00;
            is_store_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_code_q <= fault_code_d;
            is_store_q   <= is_store_d;
        end
    end

    assign fault_code = fault_code_q;
    assign state      = state_q;

endmodule

`default_nettype wire
